// File: rtl/nrzi_encoder_pkg.sv
// Shared USB definitions: transmit FSM states, line-state encodings and the NRZI step.
// The receive path reuses the same line encodings.
package nrzi_encoder_pkg;

  // Line levels are packed as {dp, dm}.
  typedef enum logic [1:0] {
    LineSe0 = 2'b00,
    LineK   = 2'b01,
    LineJ   = 2'b10
  } line_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StData   = 2'b01,
    StEopSe0 = 2'b10,
    StEopJ   = 2'b11
  } tx_state_e;

  localparam logic [2:0] OnesMax = 3'd7;
  localparam logic [2:0] OnesLimit = 3'd6;

  // A 0 bit toggles between J and K; a 1 bit holds the current level.
  function automatic line_e nrzi_next(line_e level, logic bit_val);
    if (bit_val) begin
      return level;
    end
    return (level == LineJ) ? LineK : LineJ;
  endfunction

endpackage

// File: rtl/nrzi_encoder.sv
// USB NRZI line encoder with end-of-packet generation (SE0 phase, then J, then idle)
// and a sticky flag for runs of seven or more consecutive 1 bits.
module nrzi_encoder
  import nrzi_encoder_pkg::*;
#(
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input  logic clk,
  input  logic RST,
  input  logic en,
  input  logic in_bit,
  input  logic in_valid,
  input  logic eop_req,
  output logic dp,
  output logic dm,
  output logic oe,
  output logic busy,
  output logic eop_done,
  output logic stuff_err
);

  localparam int unsigned CntW = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;
  localparam logic [CntW-1:0] Se0Last = CntW'(EOP_SE0_BITS - 1);

  tx_state_e       state_q, state_d;
  line_e           level_q, level_d;
  logic [2:0]      ones_q, ones_d;
  logic [CntW-1:0] se0_cnt_q, se0_cnt_d;
  logic            eop_pending_q, eop_pending_d;
  logic            stuff_err_q, stuff_err_d;
  logic            eop_done_q, eop_done_d;
  logic            encode;
  line_e           line;

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    ones_d        = ones_q;
    se0_cnt_d     = se0_cnt_q;
    stuff_err_d   = stuff_err_q;
    eop_done_d    = 1'b0;
    eop_pending_d = eop_pending_q | (eop_req && (state_q != StIdle));
    encode        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en && in_valid) begin
          state_d     = StData;
          stuff_err_d = 1'b0;
          encode      = 1'b1;
        end
      end
      StData: begin
        if (en) begin
          // A pending EOP waits for a strobe without a data bit so the last bit gets its slot.
          if (eop_pending_q && !in_valid) begin
            state_d   = StEopSe0;
            se0_cnt_d = '0;
          end else begin
            encode = in_valid;
          end
        end
      end
      StEopSe0: begin
        if (en) begin
          if (se0_cnt_q == Se0Last) begin
            state_d = StEopJ;
          end else begin
            se0_cnt_d = se0_cnt_q + 1'b1;
          end
        end
      end
      StEopJ: begin
        if (en) begin
          state_d       = StIdle;
          level_d       = LineJ;
          ones_d        = '0;
          se0_cnt_d     = '0;
          eop_pending_d = 1'b0;
          eop_done_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (encode) begin
      level_d = nrzi_next(level_q, in_bit);
      if (in_bit) begin
        if (ones_q >= OnesLimit) begin
          stuff_err_d = 1'b1;
        end
        ones_d = (ones_q == OnesMax) ? OnesMax : ones_q + 3'd1;
      end else begin
        ones_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q       <= StIdle;
      level_q       <= LineJ;
      ones_q        <= '0;
      se0_cnt_q     <= '0;
      eop_pending_q <= 1'b0;
      stuff_err_q   <= 1'b0;
      eop_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      ones_q        <= ones_d;
      se0_cnt_q     <= se0_cnt_d;
      eop_pending_q <= eop_pending_d;
      stuff_err_q   <= stuff_err_d;
      eop_done_q    <= eop_done_d;
    end
  end

  always_comb begin
    line = LineJ;
    unique case (state_q)
      StData:   line = level_q;
      StEopSe0: line = LineSe0;
      default:  line = LineJ;
    endcase
  end

  assign {dp, dm}  = line;
  assign oe        = (state_q != StIdle);
  assign busy      = (state_q != StIdle);
  assign eop_done  = eop_done_q;
  assign stuff_err = stuff_err_q;

endmodule

// File: tb/tb_nrzi_encoder.sv
// Directed bench for nrzi_encoder: NRZI toggling, gaps, EOP sequencing, stuff error,
// asynchronous reset mid-EOP and eop_req ignored while idle.
module tb_nrzi_encoder;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic clk = 1'b0;
  logic RST = 1'b1;
  logic en = 1'b0;
  logic in_bit = 1'b0;
  logic in_valid = 1'b0;
  logic eop_req = 1'b0;
  logic dp, dm, oe, busy, eop_done, stuff_err;

  int n_checks = 0;
  int n_fail = 0;

  nrzi_encoder #(.EOP_SE0_BITS(2)) dut (
    .clk       (clk),
    .RST       (RST),
    .en        (en),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .eop_req   (eop_req),
    .dp        (dp),
    .dm        (dm),
    .oe        (oe),
    .busy      (busy),
    .eop_done  (eop_done),
    .stuff_err (stuff_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One bit-time strobe; returns 1 time unit after the capturing edge.
  task automatic strobe(input logic b, input logic v, input logic e);
    en = 1'b1;
    in_bit = b;
    in_valid = v;
    eop_req = e;
    @(posedge clk);
    #1;
    en = 1'b0;
    in_bit = 1'b0;
    in_valid = 1'b0;
    eop_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_line", {1'b0, dp, dm}, {1'b0, J});
    chk("rst_oe", {2'b0, oe}, 3'd0);
    chk("rst_busy", {2'b0, busy}, 3'd0);
    chk("rst_done", {2'b0, eop_done}, 3'd0);
    chk("rst_err", {2'b0, stuff_err}, 3'd0);
    RST = 1'b0;
    tick();

    // Bits 0,0,1,0 -> K,J,J,K
    strobe(1'b0, 1'b1, 1'b0);
    chk("b0_line", {1'b0, dp, dm}, {1'b0, K});
    chk("b0_oe", {2'b0, oe}, 3'd1);
    chk("b0_busy", {2'b0, busy}, 3'd1);
    strobe(1'b0, 1'b1, 1'b0);
    chk("b1_line", {1'b0, dp, dm}, {1'b0, J});
    strobe(1'b1, 1'b1, 1'b0);
    chk("b2_line", {1'b0, dp, dm}, {1'b0, J});
    strobe(1'b0, 1'b1, 1'b0);
    chk("b3_line", {1'b0, dp, dm}, {1'b0, K});

    // No strobe: a valid 0 must not toggle
    in_valid = 1'b1;
    in_bit = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("en_gate", {1'b0, dp, dm}, {1'b0, K});

    // Bit 1, gap, bit 0
    strobe(1'b1, 1'b1, 1'b0);
    chk("gap_pre", {1'b0, dp, dm}, {1'b0, K});
    chk("ones_pre", dut.ones_q, 3'd1);
    strobe(1'b1, 1'b0, 1'b0);
    chk("gap_line", {1'b0, dp, dm}, {1'b0, K});
    chk("gap_ones", dut.ones_q, 3'd1);
    strobe(1'b0, 1'b1, 1'b0);
    chk("gap_post", {1'b0, dp, dm}, {1'b0, J});
    chk("ones_clr", dut.ones_q, 3'd0);

    // EOP requested together with the last bit
    strobe(1'b0, 1'b1, 1'b1);
    chk("eop_bit", {1'b0, dp, dm}, {1'b0, K});
    strobe(1'b0, 1'b0, 1'b0);
    chk("se0_1", {1'b0, dp, dm}, {1'b0, SE0});
    chk("se0_oe", {2'b0, oe}, 3'd1);
    strobe(1'b0, 1'b1, 1'b0);
    chk("se0_2", {1'b0, dp, dm}, {1'b0, SE0});
    strobe(1'b0, 1'b0, 1'b0);
    chk("eopj_line", {1'b0, dp, dm}, {1'b0, J});
    chk("eopj_oe", {2'b0, oe}, 3'd1);
    chk("eopj_done", {2'b0, eop_done}, 3'd0);
    strobe(1'b0, 1'b0, 1'b0);
    chk("idle_done", {2'b0, eop_done}, 3'd1);
    chk("idle_oe", {2'b0, oe}, 3'd0);
    chk("idle_busy", {2'b0, busy}, 3'd0);
    chk("idle_line", {1'b0, dp, dm}, {1'b0, J});
    tick();
    chk("done_pulse", {2'b0, eop_done}, 3'd0);

    // Seven consecutive ones
    for (int i = 1; i <= 7; i++) begin
      strobe(1'b1, 1'b1, 1'b0);
      if (i == 6) chk("err_at6", {2'b0, stuff_err}, 3'd0);
    end
    chk("err_at7", {2'b0, stuff_err}, 3'd1);
    chk("ones_line", {1'b0, dp, dm}, {1'b0, J});
    strobe(1'b0, 1'b1, 1'b1);
    chk("err_bit0", {1'b0, dp, dm}, {1'b0, K});
    for (int i = 0; i < 4; i++) begin
      strobe(1'b0, 1'b0, 1'b0);
      chk("err_eop", {2'b0, stuff_err}, 3'd1);
    end
    chk("err_done", {2'b0, eop_done}, 3'd1);
    strobe(1'b0, 1'b1, 1'b0);
    chk("err_clr", {2'b0, stuff_err}, 3'd0);
    chk("pkt2_line", {1'b0, dp, dm}, {1'b0, K});

    // eop_req on a non-strobe cycle is still captured; reset during SE0
    eop_req = 1'b1;
    tick();
    eop_req = 1'b0;
    strobe(1'b0, 1'b0, 1'b0);
    chk("cap_se0", {1'b0, dp, dm}, {1'b0, SE0});
    #3;
    RST = 1'b1;
    #1;
    chk("arst_line", {1'b0, dp, dm}, {1'b0, J});
    chk("arst_oe", {2'b0, oe}, 3'd0);
    chk("arst_busy", {2'b0, busy}, 3'd0);
    tick();
    chk("arst_done", {2'b0, eop_done}, 3'd0);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      strobe(1'b0, 1'b0, 1'b0);
      chk("arst_nodone", {2'b0, eop_done}, 3'd0);
    end

    // eop_req while idle is ignored
    strobe(1'b0, 1'b0, 1'b1);
    chk("idle_req", {2'b0, busy}, 3'd0);
    strobe(1'b1, 1'b1, 1'b0);
    chk("new_j", {1'b0, dp, dm}, {1'b0, J});
    chk("new_busy", {2'b0, busy}, 3'd1);
    strobe(1'b0, 1'b1, 1'b0);
    chk("new_k", {1'b0, dp, dm}, {1'b0, K});
    strobe(1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0);
    chk("no_eop", {1'b0, dp, dm}, {1'b0, K});
    chk("no_eop_busy", {2'b0, busy}, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nrzi_encoder.md
NRZI_ENCODER -- requirements
Module: nrzi_encoder

Interface
REQ-001 Parameter EOP_SE0_BITS, default 2: number of bit strobes the SE0 phase of end-of-packet lasts (legal range 1..3).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-high; forces the reset state immediately on assertion.
REQ-004 en  input  1  bit-time strobe; state advances only in cycles where en=1, except reset and eop_req capture.
REQ-005 in_bit  input  1  stuffed serial data bit from the bit-stuffing stage.
REQ-006 in_valid  input  1  in_bit is a real bit this strobe; 0 means hold line (stuff slot / gap).
REQ-007 eop_req  input  1  one-cycle pulse requesting end-of-packet after the last data bit.
REQ-008 dp  output  1  D+ line level.
REQ-009 dm  output  1  D- line level.
REQ-010 oe  output  1  line driver output enable.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 eop_done  output  1  one-cycle pulse when EOP completes.
REQ-013 stuff_err  output  1  sticky flag: more than six consecutive 1 bits encoded in one packet.

Function
REQ-014 Line states: J = dp1/dm0, K = dp0/dm1, SE0 = dp0/dm0; dp/dm never both 1.
REQ-015 FSM states IDLE, DATA, EOP_SE0, EOP_J; all transitions occur only on cycles with en=1.
REQ-016 IDLE: oe=0, line J, level register = J; en=1 and in_valid=1 -> DATA, encoding that bit in the same strobe.
REQ-017 NRZI: valid bit 0 toggles level (J<->K), valid bit 1 holds level; registered update, dp/dm change one clock after the strobe that carries the bit.
REQ-018 DATA with in_valid=0 on a strobe: level held, ones counter unchanged.
REQ-019 eop_req is captured into eop_pending on any clk cycle, regardless of en; eop_req while IDLE is ignored.
REQ-020 DATA with en=1 and eop_pending=1: if in_valid=1 the bit is encoded first and EOP_SE0 entered at the next strobe; if in_valid=0, EOP_SE0 is entered on this strobe.
REQ-021 EOP_SE0: oe=1, line SE0 for exactly EOP_SE0_BITS strobes, then EOP_J.
REQ-022 EOP_J: oe=1, line J for one strobe, then IDLE; eop_done pulses for the clock on which IDLE is entered; eop_pending cleared.
REQ-023 Valid bits presented during EOP_SE0/EOP_J are discarded; line unaffected.
REQ-024 Ones counter: 3-bit, increments on valid 1, clears on valid 0 or IDLE entry; a 7th consecutive valid 1 sets stuff_err, which is cleared only on the next IDLE->DATA transition or reset.
REQ-025 Strobe counter for EOP_SE0 sized for EOP_SE0_BITS; no wrap beyond the terminal count.

Reset
REQ-026 RST asserted: state IDLE, level J, dp=1, dm=0, oe=0, busy=0, eop_done=0, stuff_err=0, eop_pending=0, counters 0.
REQ-027 RST mid-packet (any state): outputs return to the reset values asynchronously; no partial EOP is emitted.

Structure
REQ-028 The state enum and line-state encodings (J, K, SE0) reside in a shared USB package reused by the receive path.
REQ-029 Single flat module; no sub-modules.

Verification
REQ-030 Reset, then valid bits 0,0,1,0 on successive strobes -> line K,J,J,K; oe=1 from the first strobe; busy=1.
REQ-031 Bits 1,0 with in_valid=0 strobe between them -> line held across the gap, then toggles; ones counter unchanged in the gap.
REQ-032 eop_req with in_valid=1 on the same strobe -> bit encoded, then SE0 for 2 strobes, J for 1 strobe, eop_done pulse, oe=0, busy=0.
REQ-033 Seven consecutive valid 1s -> stuff_err=1 after the 7th; stays 1 through EOP; clears when the next packet starts.
REQ-034 RST asserted during EOP_SE0 -> dp=1, dm=0, oe=0 immediately; no eop_done pulse.
REQ-035 eop_req in IDLE, then a new packet -> no EOP is emitted and encoding starts normally from J.
